pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 3, meaning register-index width (2**REG_WIDTH architectural registers).
REQ-002 SHALL have parameter NUM_STAGES, default 3, meaning count of tracked stages after decode (1=EX, 2=MEM, 3=WB).
REQ-003 SHALL have parameter LOAD_STAGE, default 2, meaning first stage whose output holds load data (1 <= LOAD_STAGE <= NUM_STAGES).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning stall-counter width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port id_valid, input, 1, meaning the ID stage holds a real instruction.
REQ-008 SHALL have ports id_rs1 and id_rs2, input, REG_WIDTH each, meaning ID source registers.
REQ-009 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each, meaning the source is actually read.
REQ-010 SHALL have ports id_rd (input, REG_WIDTH), id_regwrite (input, 1) and id_memread (input, 1), meaning ID destination, writes-register and is-load.
REQ-011 SHALL have port flush, input, 1, meaning the branch/jump resolved in ID redirects the PC.
REQ-012 SHALL have ports stall, pc_write and ifid_write, output, 1 each, meaning hold the front end.
REQ-013 SHALL have ports fwd_a and fwd_b, output, $clog2(NUM_STAGES+1) each, meaning the operand source: 0=register file, k=stage k result.
REQ-014 SHALL have port stall_cnt, output, CNT_WIDTH, meaning count of stall cycles.

Function
REQ-015 SHALL keep per stage k an entry {valid, rd, regwrite, ready_stage}, where ready_stage = LOAD_STAGE for loads and 1 otherwise.
REQ-016 SHALL shift entries each cycle: entry[k] <= entry[k-1] for k >= 2, and entry[NUM_STAGES] retires.
REQ-017 SHALL load entry[1] from ID when id_valid & !stall & !flush, else load a bubble (valid=0).
REQ-018 SHALL treat a stage k as matching a source when valid & regwrite & rd == source & the use bit is set.
REQ-019 SHALL use the youngest match (lowest k) only; older matches are ignored.
REQ-020 SHALL assert stall combinationally when id_valid and the youngest match of either source has ready_stage > k.
REQ-021 SHALL drive fwd_x = k for the youngest match when it is ready, and 0 when there is no match.
REQ-022 SHALL drive pc_write = ifid_write = !stall | flush.
REQ-023 SHALL give flush priority over stall: stall is forced to 0 and a bubble enters stage 1.
REQ-024 SHALL increment stall_cnt on each cycle with stall=1, saturating at all-ones without wrap.
REQ-025 SHALL forward register 0 like any other register; no hard-wired zero register exists.

Reset
REQ-026 SHALL, while rst=0, clear all entry valid bits and stall_cnt asynchronously.
REQ-027 SHALL therefore give, in reset, stall=0, pc_write=1, ifid_write=1, fwd_a=fwd_b=0.
REQ-028 SHALL, on reset mid-stall, discard all in-flight entries and report no hazard on the first post-reset cycle.

Configuration
REQ-029 SHALL honour macro PIPE_FWD_EN: when defined, forwarding follows REQ-020 and REQ-021.
REQ-030 SHALL, when PIPE_FWD_EN is undefined, tie fwd_a and fwd_b to 0 and assert stall on any match in any stage (interlock-only).

Structure
REQ-031 SHALL place fwd_sel_t, the stage-entry struct and the default constants in shared package pipe_pkg.
REQ-032 SHALL implement the per-operand youngest-match priority encoder as sub-module fwd_select, instantiated once per source.

Verification
REQ-033 SHALL check ALU back-to-back: "add r1" then "sub r2,r1,r3" -> fwd_a=1, stall=0.
REQ-034 SHALL check load-use: "lw r4" then "add r5,r4,r4" -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=2, and stall_cnt=1.
REQ-035 SHALL check youngest-wins: writes to r2 in stage 3 and stage 1 -> fwd_b=1.
REQ-036 SHALL check flush during a load-use stall -> stall=0, pc_write=1, next entry[1].valid=0.
REQ-037 SHALL check rst asserted low mid-stall -> all outputs return to reset values immediately; stall_cnt=0.
REQ-038 SHALL check a build without PIPE_FWD_EN: "add r1" followed by a reader of r1 -> stall for 3 cycles, fwd=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its
// forwarding selectors (PIPE_FWD_EN selects forwarding vs. interlock-only).
package pipe_pkg;

    localparam int DEF_REG_WIDTH  = 3;
    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_LOAD_STAGE = 2;
    localparam int DEF_CNT_WIDTH  = 16;

    // Entries hold register indices up to this width and stage numbers up to 15.
    localparam int RD_MAX_W = 8;
    localparam int STG_W    = 4;

    typedef logic [STG_W-1:0] fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        fwd_sel_t            ready_stage;
    } stage_entry_t;

    localparam fwd_sel_t STAGE_EX = 4'd1;

    localparam stage_entry_t BUBBLE_ENTRY = '{
        valid:       1'b0,
        rd:          {RD_MAX_W{1'b0}},
        regwrite:    1'b0,
        ready_stage: STAGE_EX
    };

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Youngest-match priority encoder for one ID source operand.
// With PIPE_FWD_EN the result feeds forwarding; without it any match interlocks.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int FW         = 2
) (
    input  stage_entry_t         entries [1:NUM_STAGES],
    input  logic [REG_WIDTH-1:0] src,
    input  logic                 use_src,
    output logic                 stall_req,
    output logic [FW-1:0]        fwd
);

    logic [NUM_STAGES:1] match_s;
    logic                hit_s;
    fwd_sel_t            hit_stage_s;
    logic                not_ready_s;

    // Per-stage match of a live register writer against the source index
    always_comb begin
        match_s = {NUM_STAGES{1'b0}};
        for (int k = 1; k <= NUM_STAGES; k++) begin
            match_s[k] = use_src & entries[k].valid & entries[k].regwrite &
                         (entries[k].rd == RD_MAX_W'(src));
        end
    end

    // Scan oldest to youngest so the lowest matching stage is the one kept
    always_comb begin
        hit_s       = 1'b0;
        hit_stage_s = {STG_W{1'b0}};
        not_ready_s = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            hit_s       = hit_s | match_s[k];
            hit_stage_s = match_s[k] ? fwd_sel_t'(k) : hit_stage_s;
            not_ready_s = match_s[k] ? (entries[k].ready_stage > fwd_sel_t'(k)) : not_ready_s;
        end
    end

`ifdef PIPE_FWD_EN
    assign stall_req = hit_s & not_ready_s;
    assign fwd       = (hit_s & ~not_ready_s) ? FW'(hit_stage_s) : {FW{1'b0}};
`else
    logic unused_s;
    assign unused_s  = ^{hit_stage_s, not_ready_s};
    assign stall_req = hit_s;
    assign fwd       = {FW{1'b0}};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Data-hazard controller: tracks in-flight destinations, stalls the front end
// and selects operand forwarding. Forwarding is built only with PIPE_FWD_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int LOAD_STAGE = DEF_LOAD_STAGE,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_WIDTH-1:0]              id_rs1,
    input  logic [REG_WIDTH-1:0]              id_rs2,
    input  logic                              id_use_rs1,
    input  logic                              id_use_rs2,
    input  logic [REG_WIDTH-1:0]              id_rd,
    input  logic                              id_regwrite,
    input  logic                              id_memread,
    input  logic                              flush,
    output logic                              stall,
    output logic                              pc_write,
    output logic                              ifid_write,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_a,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_b,
    output logic [CNT_WIDTH-1:0]              stall_cnt
);

    localparam int FW = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    stage_entry_t entries_r [1:NUM_STAGES];
    stage_entry_t id_entry_s;
    logic         stall_a_s;
    logic         stall_b_s;
    logic         stall_s;

    fwd_select #(
        .REG_WIDTH  (REG_WIDTH),
        .NUM_STAGES (NUM_STAGES),
        .FW         (FW)
    ) u_sel_a (
        .entries   (entries_r),
        .src       (id_rs1),
        .use_src   (id_use_rs1),
        .stall_req (stall_a_s),
        .fwd       (fwd_a)
    );

    fwd_select #(
        .REG_WIDTH  (REG_WIDTH),
        .NUM_STAGES (NUM_STAGES),
        .FW         (FW)
    ) u_sel_b (
        .entries   (entries_r),
        .src       (id_rs2),
        .use_src   (id_use_rs2),
        .stall_req (stall_b_s),
        .fwd       (fwd_b)
    );

    // A redirect discards the ID instruction, so it never waits on a hazard
    always_comb begin
        stall_s = 1'b0;
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = id_valid & (stall_a_s | stall_b_s);
        end
    end

    assign stall      = stall_s;
    assign pc_write   = ~stall_s | flush;
    assign ifid_write = ~stall_s | flush;

    // Next stage-1 entry: the ID instruction if it issues, otherwise a bubble
    always_comb begin
        id_entry_s = BUBBLE_ENTRY;
        if (id_valid && !stall_s && !flush) begin
            id_entry_s.valid       = 1'b1;
            id_entry_s.rd          = RD_MAX_W'(id_rd);
            id_entry_s.regwrite    = id_regwrite;
            id_entry_s.ready_stage = id_memread ? fwd_sel_t'(LOAD_STAGE) : STAGE_EX;
        end else begin
            id_entry_s = BUBBLE_ENTRY;
        end
    end

    // Shift in-flight destinations down the pipe; the last stage retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                entries_r[k] <= BUBBLE_ENTRY;
            end
        end else begin
            entries_r[1] <= id_entry_s;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                entries_r[k] <= entries_r[k-1];
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= {CNT_WIDTH{1'b0}};
        end else if (stall_s && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed table, multi-cycle corner sequences and
// random traffic against a queue-based model. Honours PIPE_FWD_EN like the RTL.
module tb_pipe_hazard_ctrl;

    localparam int RW = 3;
    localparam int NS = 3;
    localparam int LS = 2;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_FWD_EN
    localparam bit FWD_MODE = 1'b1;
`else
    localparam bit FWD_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic stall, pc_write, ifid_write;
    logic [$clog2(NS+1)-1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_WIDTH (RW),
        .NUM_STAGES(NS),
        .LOAD_STAGE(LS),
        .CNT_WIDTH (CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: queue of issued instructions, index 0 = stage 1 (youngest)
    typedef struct { bit v; int rd; bit wr; bit ld; } instr_t;
    instr_t hist[$];
    int     m_cnt = 0;

    bit last_stall;
    int last_fa, last_fb;

    typedef struct {
        bit v; int r1; int r2; bit u1; bit u2; int rd; bit rw; bit mr; bit fl;
        bit xs_f; int xa_f; int xb_f;
        bit xs_i; int xa_i; int xb_i;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void src_eval(input int src, input bit use_it, output bit hazard, output int fwd);
        hazard = 1'b0;
        fwd    = 0;
        if (use_it) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (hist[i].v && hist[i].wr && hist[i].rd == src) begin
                    if (!FWD_MODE) hazard = 1'b1;
                    else if (hist[i].ld && (i + 1) < LS) hazard = 1'b1;
                    else fwd = i + 1;
                    return;
                end
            end
        end
    endfunction

    task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit fl,
                        input bit has_exp, input bit xs, input int xa, input int xb, input string tag);
        bit hz_a, hz_b, e_stall;
        int e_fa, e_fb;
        instr_t ni;
        id_valid = v; id_rs1 = RW'(r1); id_rs2 = RW'(r2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RW'(rd);
        id_regwrite = rw; id_memread = mr; flush = fl;
        #2;
        src_eval(r1, u1, hz_a, e_fa);
        src_eval(r2, u2, hz_b, e_fb);
        e_stall = v && (hz_a || hz_b) && !fl;
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".pc_write"}, 32'(pc_write), 32'(!e_stall || fl));
        chk({tag, ".ifid_write"}, 32'(ifid_write), 32'(!e_stall || fl));
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(e_fa));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(e_fb));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        if (has_exp) begin
            chk({tag, ".tab_stall"}, 32'(stall), 32'(xs));
            chk({tag, ".tab_fwd_a"}, 32'(fwd_a), 32'(xa));
            chk({tag, ".tab_fwd_b"}, 32'(fwd_b), 32'(xb));
        end
        last_stall = stall;
        last_fa = int'(fwd_a);
        last_fb = int'(fwd_b);
        @(posedge clk);
        ni.v = v && !e_stall && !fl; ni.rd = rd; ni.wr = rw; ni.ld = mr;
        hist.push_front(ni);
        if (hist.size() > NS) void'(hist.pop_back());
        if (e_stall && m_cnt < CMAX) m_cnt++;
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        #3;
        chk("rst.stall", 32'(stall), 32'(0));
        chk("rst.pc_write", 32'(pc_write), 32'(1));
        chk("rst.ifid_write", 32'(ifid_write), 32'(1));
        chk("rst.fwd_a", 32'(fwd_a), 32'(0));
        chk("rst.fwd_b", 32'(fwd_b), 32'(0));
        chk("rst.stall_cnt", 32'(stall_cnt), 32'(0));
        hist.delete();
        m_cnt = 0;
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic row(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit fl,
                       input bit xsf, input int xaf, input int xbf,
                       input bit xsi, input int xai, input int xbi);
        vec_t e;
        e.v = v; e.r1 = r1; e.r2 = r2; e.u1 = u1; e.u2 = u2; e.rd = rd; e.rw = rw; e.mr = mr; e.fl = fl;
        e.xs_f = xsf; e.xa_f = xaf; e.xb_f = xbf; e.xs_i = xsi; e.xa_i = xai; e.xb_i = xbi;
        tab.push_back(e);
    endtask

    task automatic drain_rows();
        for (int i = 0; i < 3; i++) row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_stall;
        // ALU back-to-back: add r1, then four readers of r1
        row(1, 5, 6, 1, 1, 1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        row(1, 1, 3, 1, 1, 2, 1, 0, 0,   0, 1, 0,   1, 0, 0);
        row(1, 1, 3, 1, 1, 2, 1, 0, 0,   0, 2, 0,   1, 0, 0);
        row(1, 1, 3, 1, 1, 2, 1, 0, 0,   0, 3, 0,   1, 0, 0);
        row(1, 1, 3, 1, 1, 2, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        drain_rows();
        // Load-use: lw r4, then add r5,r4,r4
        row(1, 7, 0, 1, 0, 4, 1, 1, 0,   0, 0, 0,   0, 0, 0);
        row(1, 4, 4, 1, 1, 5, 1, 0, 0,   1, 0, 0,   1, 0, 0);
        row(1, 4, 4, 1, 1, 5, 1, 0, 0,   0, 2, 2,   1, 0, 0);
        row(1, 4, 4, 1, 1, 5, 1, 0, 0,   0, 3, 3,   1, 0, 0);
        row(1, 4, 4, 1, 1, 5, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        drain_rows();
        // Youngest wins: r2 written in stages 3 and 1, read on rs2
        row(1, 0, 0, 0, 0, 2, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        row(1, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        row(1, 0, 0, 0, 0, 2, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        row(1, 0, 2, 0, 1, 3, 1, 0, 0,   0, 0, 1,   1, 0, 0);
        row(1, 0, 2, 0, 1, 3, 1, 0, 0,   0, 0, 2,   1, 0, 0);
        row(1, 0, 2, 0, 1, 3, 1, 0, 0,   0, 0, 3,   1, 0, 0);
        row(1, 0, 2, 0, 1, 3, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        drain_rows();
        // r0 forwards like any register; rs2=r0 with its use bit clear never matches
        row(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        row(1, 0, 0, 1, 0, 5, 0, 0, 0,   0, 1, 0,   1, 0, 0);
        row(1, 0, 0, 1, 0, 5, 0, 0, 0,   0, 2, 0,   1, 0, 0);
        row(1, 0, 0, 1, 0, 5, 0, 0, 0,   0, 3, 0,   1, 0, 0);
        row(1, 0, 0, 1, 0, 5, 0, 0, 0,   0, 0, 0,   0, 0, 0);
        drain_rows();
        // Flush during a load-use stall: the flushed add must not enter stage 1
        row(1, 7, 0, 1, 0, 4, 1, 1, 0,   0, 0, 0,   0, 0, 0);
        row(1, 4, 4, 1, 1, 5, 1, 0, 1,   0, 0, 0,   0, 0, 0);
        row(1, 5, 5, 1, 1, 6, 1, 0, 0,   0, 0, 0,   0, 0, 0);

        do_reset();

        // Load-use from a clean pipe: count stall cycles and stall_cnt
        step(1, 7, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, "lu_lw");
        n_stall = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 4, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, "lu_add");
            if (!last_stall) break;
            n_stall++;
        end
        chk("lu_stall_cycles", 32'(n_stall), FWD_MODE ? 32'd1 : 32'd3);
        chk("lu_fwd_a", 32'(last_fa), FWD_MODE ? 32'd2 : 32'd0);
        chk("lu_fwd_b", 32'(last_fb), FWD_MODE ? 32'd2 : 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), FWD_MODE ? 32'd1 : 32'd3);

        // Reset asserted in the middle of a load-use stall
        step(1, 7, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0, "rs_lw");
        id_valid = 1'b1; id_rs1 = 3'd6; id_rs2 = 3'd6; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_rd = 3'd7; id_regwrite = 1'b1; id_memread = 1'b0; flush = 1'b0;
        #2;
        chk("rs_pre.stall", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("rs_mid.stall", 32'(stall), 32'd0);
        chk("rs_mid.pc_write", 32'(pc_write), 32'd1);
        chk("rs_mid.ifid_write", 32'(ifid_write), 32'd1);
        chk("rs_mid.fwd_a", 32'(fwd_a), 32'd0);
        chk("rs_mid.fwd_b", 32'(fwd_b), 32'd0);
        chk("rs_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        hist.delete();
        m_cnt = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        step(1, 6, 6, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0, "rs_post");

        // Directed table
        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].v, tab[i].r1, tab[i].r2, tab[i].u1, tab[i].u2, tab[i].rd,
                 tab[i].rw, tab[i].mr, tab[i].fl, 1'b1,
                 FWD_MODE ? tab[i].xs_f : tab[i].xs_i,
                 FWD_MODE ? tab[i].xa_f : tab[i].xa_i,
                 FWD_MODE ? tab[i].xb_f : tab[i].xb_i,
                 $sformatf("tab%0d", i));
        end
        idle("tab_end");

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 1'b0, 1'b0, 0, 0, "rnd");
        end

        // Drive the stall counter into saturation and keep stalling
        for (int i = 0; i < 300 && m_cnt < CMAX; i++) begin
            step(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, "sat_fill");
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, "sat_hold");
        end
        chk("sat.stall_cnt", 32'(stall_cnt), 32'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
